// File: rtl/sap_core.sv
// SAP-style CPU core: PC, A/B, IR, MAR, RAM, ALU+flags, variable-length microcode, one T-state per step_en edge.
// Latency 3-5 enabled edges per instruction; step_en stalls the sequencer, prog_mode holds it cleared.
module sap_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step_en,
    input  logic              prog_mode,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted,
    output logic              cf,
    output logic              zf,
    output logic [ADDR_W-1:0] pc_dbg
);
    typedef enum logic [2:0] {T0, T1, T2, T3, T4} tstate_t;

    localparam logic [3:0] OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3, OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC  = 4'h7, OP_JZ  = 4'h8;
    localparam logic [3:0] OP_ADI = 4'h9, OP_SBI = 4'hA, OP_OUT = 4'hE, OP_HLT = 4'hF;

    logic [DATA_W-1:0] ram_q [2**ADDR_W];
    logic [ADDR_W-1:0] pc_q, mar_q, ir_arg_q;
    logic [3:0]        ir_op_q;
    logic [DATA_W-1:0] a_q, b_q, out_q;
    logic              cf_q, zf_q, outv_q, halt_q;
    tstate_t           t_q, t_d, t_last;

    logic [DATA_W-1:0] ram_rd, imm, b_eff, ram_wd;
    logic [DATA_W:0]   alu_sum;
    logic [ADDR_W-1:0] ram_wa;
    logic              is_sub, advance, ram_we;

    // Only opcode and operand are kept; the bits between them are ignored.
    assign ram_rd  = ram_q[mar_q];
    assign imm     = {{(DATA_W-ADDR_W){1'b0}}, ir_arg_q};
    assign is_sub  = (ir_op_q == OP_SUB) || (ir_op_q == OP_SBI);
    assign b_eff   = is_sub ? ~b_q : b_q;
    assign alu_sum = {1'b0, a_q} + {1'b0, b_eff} + {{DATA_W{1'b0}}, is_sub};
    assign advance = step_en && !halt_q;

    always_comb begin
        case (ir_op_q)
            OP_LDA, OP_STA, OP_ADI, OP_SBI: t_last = T3;
            OP_ADD, OP_SUB:                 t_last = T4;
            default:                        t_last = T2;
        endcase
        t_d = (t_q == t_last) ? T0 : tstate_t'(t_q + 3'd1);
    end

    always_comb begin
        ram_we = 1'b0;
        ram_wa = mar_q;
        ram_wd = a_q;
        if (rst) begin
            if (prog_mode) begin
                ram_we = prog_we;
                ram_wa = prog_addr;
                ram_wd = prog_data;
            end else begin
                ram_we = advance && (t_q == T3) && (ir_op_q == OP_STA);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram_q[ram_wa] <= ram_wd;
    end

    always_ff @(posedge clk) begin
        outv_q <= 1'b0;
        if (!rst) begin
            pc_q <= '0; mar_q <= '0; ir_op_q <= '0; ir_arg_q <= '0;
            a_q <= '0; b_q <= '0; out_q <= '0;
            cf_q <= 1'b0; zf_q <= 1'b0; halt_q <= 1'b0; t_q <= T0;
        end else if (prog_mode) begin
            pc_q <= '0; mar_q <= '0; ir_op_q <= '0; ir_arg_q <= '0;
            a_q <= '0; b_q <= '0;
            cf_q <= 1'b0; zf_q <= 1'b0; halt_q <= 1'b0; t_q <= T0;
        end else if (advance) begin
            t_q <= t_d;
            case (t_q)
                T0: mar_q <= pc_q;
                T1: begin
                    ir_op_q  <= ram_rd[DATA_W-1 -: 4];
                    ir_arg_q <= ram_rd[ADDR_W-1:0];
                    pc_q     <= pc_q + ADDR_W'(1);
                end
                T2: case (ir_op_q)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: mar_q <= ir_arg_q;
                    OP_LDI:         a_q <= imm;
                    OP_JMP:         pc_q <= ir_arg_q;
                    OP_JC:          if (cf_q) pc_q <= ir_arg_q;
                    OP_JZ:          if (zf_q) pc_q <= ir_arg_q;
                    OP_ADI, OP_SBI: b_q <= imm;
                    OP_OUT: begin
                        out_q  <= a_q;
                        outv_q <= 1'b1;
                    end
                    OP_HLT:         halt_q <= 1'b1;
                    default: ;
                endcase
                T3: case (ir_op_q)
                    OP_LDA:         a_q <= ram_rd;
                    OP_ADD, OP_SUB: b_q <= ram_rd;
                    OP_ADI, OP_SBI: begin
                        a_q  <= alu_sum[DATA_W-1:0];
                        cf_q <= alu_sum[DATA_W];
                        zf_q <= (alu_sum[DATA_W-1:0] == '0);
                    end
                    default: ;
                endcase
                T4: if (ir_op_q == OP_ADD || ir_op_q == OP_SUB) begin
                    a_q  <= alu_sum[DATA_W-1:0];
                    cf_q <= alu_sum[DATA_W];
                    zf_q <= (alu_sum[DATA_W-1:0] == '0);
                end
                default: ;
            endcase
        end
    end

    assign out_data  = out_q;
    assign out_valid = outv_q;
    assign halted    = halt_q;
    assign cf        = cf_q;
    assign zf        = zf_q;
    assign pc_dbg    = pc_q;
endmodule

// File: doc/sap_core.md
# sap_core

Parametrised single-clock SAP-style CPU core, the successor to the current 8-bit breadboard computer top level. It integrates the following into one synchronous block:
- PC, A/B registers, IR, MAR, internal RAM, ALU with flags, and a variable-length microcode sequencer.
- A clock-enable input (`step_en`) in place of a gated slow clock.
- Conditional jumps, immediate arithmetic, and an output strobe.

It sits under the chip top. The clock divider drives `step_en`, and the programming pins drive the `prog_*` ports.

## Interface
- DATA_W, 8, data/instruction width; must satisfy DATA_W >= ADDR_W+4
- ADDR_W, 4, RAM address width; RAM depth is 2^ADDR_W words

- clk  input  1  system clock
- rst  input  1  synchronous, active-low reset
- step_en  input  1  advances the sequencer one T-state on a clk edge where it is high
- prog_mode  input  1  1 = program/hold mode, 0 = run
- prog_we  input  1  RAM write strobe; honoured only when prog_mode=1
- prog_addr  input  ADDR_W  program-mode write address
- prog_data  input  DATA_W  program-mode write data
- out_data  output  DATA_W  output register
- out_valid  output  1  one-clk pulse when out_data is loaded
- halted  output  1  core is halted
- cf, zf  output  1 each  carry flag and zero flag
- pc_dbg  output  ADDR_W  current PC

## Operation
- Instruction format:
  - opcode = instr[DATA_W-1:DATA_W-4].
  - operand = instr[ADDR_W-1:0].
  - Bits between the opcode and the operand are ignored.
  - Immediates are the operand, zero-extended to DATA_W.
- Priority, highest first: rst, then prog_mode, then halted, then step_en.
- Reset clears PC, A, B, IR, MAR, the step counter, cf, zf, out_data, out_valid and halted. RAM contents are not reset.
- prog_mode=1:
  - Every clk with prog_we=1 writes RAM[prog_addr] <= prog_data, independent of step_en.
  - PC, A, B, IR, MAR, the step counter, flags and halted are held cleared. out_data is retained.
  - After prog_mode falls, execution starts with a fetch from address 0.
- RAM read is combinational from MAR. RAM write is synchronous.
- Sequencer T-states; each enabled edge moves one state:
  - T0: MAR <= PC.
  - T1: IR <= RAM[MAR]; PC <= PC+1, mod 2^ADDR_W.
  - T2 onward: execute. After the instruction's last state, the next state is T0.
- Opcodes, with total steps including fetch:
  - 0 NOP (3).
  - 1 LDA a: T2 MAR<=a; T3 A<=RAM (4).
  - 2 ADD a: T2 MAR<=a; T3 B<=RAM; T4 A<=A+B, flags (5).
  - 3 SUB a: as ADD, with A<=A-B (5).
  - 4 STA a: T2 MAR<=a; T3 RAM<=A (4).
  - 5 LDI i: T2 A<=i (3).
  - 6 JMP a: T2 PC<=a (3).
  - 7 JC a / 8 JZ a: T2 PC<=a if cf / zf is set; otherwise no change (3).
  - 9 ADI i / A SBI i: T2 B<=i; T3 A<=A±B, flags (4).
  - B–D: NOP (3).
  - E OUT: T2 out_data<=A, out_valid<=1 (3).
  - F HLT: T2 halted<=1 (3).
- ALU and flag rules:
  - Sums are DATA_W bits, modulo 2^DATA_W.
  - Subtraction is computed as A + ~B + 1.
  - cf = carry out of the MSB. For subtraction, cf=1 means no borrow (A>=B).
  - zf = (result == 0).
  - Flags update only on ADD, SUB, ADI and SBI.
- Halted: the sequencer freezes and step_en is ignored. Leave halt via rst or prog_mode.

## Timing
- All state changes occur on the rising edge of clk.
- Only edges with step_en=1 advance the sequencer. Throughput is one T-state per enabled edge.
- out_valid:
  - Rises on the edge that executes OUT T2.
  - Falls on the next clk edge, whatever the value of step_en.
  - Pulse width is exactly one clk.
- halted rises on the HLT T2 edge.
- Reset or prog_mode asserted mid-instruction takes effect at that edge and abandons the instruction. A pending out_valid pulse is cleared by rst only.
- A write to RAM[PC] via STA is seen by the next fetch of that address. No stale data.

## Test plan
- Reset: assert rst low with random prior state → all outputs 0 at the next edge; RAM unchanged.
- Add program (DATA_W=8, ADDR_W=4):
  - Stimulus: load RAM0=0x1E, 1=0x2F, 2=0xE0, 3=0xF0, 14=0x1C, 15=0x0E; drop prog_mode; hold step_en=1.
  - Required: on the 12th enabled edge, out_data=0x2A and out_valid pulses one clk; on the 15th edge, halted=1; cf=0, zf=0.
- Carry/branch:
  - Program LDI 0xF, ADI 0xF, SBI 0xE, with A ending at 0x10 via further ADI steps; then ADI 0xF from A=0xF1 → A=0x00, cf=1, zf=1.
  - A following JC 7 loads PC=7; JZ with zf=0 falls through.
- Subtract: A=5, SBI 7 → A=0xFE, cf=0, zf=0. SBI with an equal operand → A=0, cf=1, zf=1.
- step_en=1 every 4th clk → identical results to the add program, with 4× the edges. out_valid is still one clk wide.
- Boundaries:
  - NOPs through address 15: PC wraps and the next fetch is from 0.
  - prog_mode or rst mid-ADD, at T3: the instruction is abandoned; PC=0 on resume.
- DATA_W=12, ADDR_W=8 instance: A=0x7FF, ADD of a word 0x801 → A=0x000, cf=1, zf=1.
